// File: rtl/weapon_mode_selector_if.sv
// Player-side signal bundle between keycode decoder, mode selector and projectile/sprite logic.
// Latency: n/a (wiring only).
// Backpressure: none; keys are sampled once per frame and outputs are plain registered levels.
interface weapon_mode_selector_if #(
    parameter int MODE_W = 2
);
    logic              is_in_turn;
    logic [7:0]        keycode;
    logic              is_run;
    logic [MODE_W-1:0] weapon_mode;
    logic              mode_changed;
    logic              switch_busy;

    // Producer of turn/key/run state, consumer of the selected mode
    modport master (
        output is_in_turn,
        output keycode,
        output is_run,
        input  weapon_mode,
        input  mode_changed,
        input  switch_busy
    );

    // The mode selector itself
    modport slave (
        input  is_in_turn,
        input  keycode,
        input  is_run,
        output weapon_mode,
        output mode_changed,
        output switch_busy
    );
endinterface

// File: rtl/weapon_mode_selector.sv
// Per-player weapon-mode register: cycle key (plus direct number keys when
// WEAPON_DIRECT_SELECT_EN is defined), edge-detected presses, post-switch cooldown.
// Latency: key sampled at frame edge k updates weapon_mode/mode_changed at edge k; no backpressure.
module weapon_mode_selector #(
    parameter int         NUM_MODES       = 4,
    parameter int         MODE_W          = 2,
    parameter logic [7:0] CYCLE_KEY       = 8'd6,
    parameter logic [7:0] DIRECT_KEY_BASE = 8'd30,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input logic                    frame_clk,
    input logic                    Reset_n,
    weapon_mode_selector_if.slave  io
);

    // Elaboration-time sanity checks on the configuration
    if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_bad_num_modes
        $error("weapon_mode_selector: NUM_MODES must be 2..16");
    end
    if (MODE_W != $clog2(NUM_MODES)) begin : g_bad_mode_w
        $error("weapon_mode_selector: MODE_W must equal clog2(NUM_MODES)");
    end
    if (COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > 255) begin : g_bad_cooldown
        $error("weapon_mode_selector: COOLDOWN_FRAMES must be 0..255");
    end
    if (int'(DIRECT_KEY_BASE) + NUM_MODES > 256) begin : g_bad_key_base
        $error("weapon_mode_selector: direct key range must fit in an 8-bit keycode");
    end

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [7:0]        CD_RELOAD = 8'(COOLDOWN_FRAMES);

    // IDLE: waiting for a fresh press; HOLD: a recognised key is still down
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        key_prev_q;
    logic [7:0]        held_key_q, held_key_d;
    logic [7:0]        cd_q, cd_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              chg_q, chg_d;
    logic              busy_q, busy_d;

    logic              press;
    logic              is_cycle;
    logic              is_direct;
    logic [MODE_W-1:0] direct_tgt;
    logic              req_ok;

    // A press is any change to a nonzero keycode; held keys never repeat
    assign press    = (io.keycode != key_prev_q) && (io.keycode != 8'd0);
    assign is_cycle = (io.keycode == CYCLE_KEY);

`ifdef WEAPON_DIRECT_SELECT_EN
    logic [7:0] direct_ofs;

    // Number keys map straight onto a mode index when inside the mode range
    assign direct_ofs = io.keycode - DIRECT_KEY_BASE;
    assign is_direct  = (io.keycode >= DIRECT_KEY_BASE) && (direct_ofs < 8'(NUM_MODES));
    assign direct_tgt = direct_ofs[MODE_W-1:0];
`else
    // Only the cycle key is recognised; number keys fall through as unrelated keys
    assign is_direct  = 1'b0;
    assign direct_tgt = '0;
`endif

    // Request gating: turn owner, standing still, cooldown expired, no key still held
    assign req_ok = press && io.is_in_turn && !io.is_run && (cd_q == 8'd0) && (state_q == IDLE);

    // Next-state decode for FSM, mode register and cooldown counter
    always_comb begin
        state_d    = state_q;
        held_key_d = held_key_q;
        mode_d     = mode_q;
        chg_d      = 1'b0;
        cd_d       = (cd_q != 8'd0) ? (cd_q - 8'd1) : 8'd0;
        busy_d     = (cd_q != 8'd0);

        // Recognised presses are consumed even when rejected, so a rejected
        // key must be released and pressed again before it can count.
        case (state_q)
            IDLE: begin
                if (press && (is_cycle || is_direct)) begin
                    state_d    = HOLD;
                    held_key_d = io.keycode;
                end
            end
            HOLD: begin
                if (io.keycode != held_key_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (req_ok && is_cycle) begin
            mode_d = (mode_q == LAST_MODE) ? '0 : (mode_q + MODE_W'(1));
            chg_d  = 1'b1;
            cd_d   = CD_RELOAD;
        end else if (req_ok && is_direct && (direct_tgt != mode_q)) begin
            // Selecting the mode already active is a silent no-op (no cooldown)
            mode_d = direct_tgt;
            chg_d  = 1'b1;
            cd_d   = CD_RELOAD;
        end
    end

    // All state and registered outputs, cleared asynchronously by Reset_n
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            key_prev_q <= 8'd0;
            held_key_q <= 8'd0;
            cd_q       <= 8'd0;
            mode_q     <= '0;
            chg_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= io.keycode;
            held_key_q <= held_key_d;
            cd_q       <= cd_d;
            mode_q     <= mode_d;
            chg_q      <= chg_d;
            busy_q     <= busy_d;
        end
    end

    assign io.weapon_mode  = mode_q;
    assign io.mode_changed = chg_q;
    assign io.switch_busy  = busy_q;

endmodule
